// File: rtl/set_job_sched_pkg.sv
// Shared types and widths for the SET job scheduler.
// Imported by the scheduler top and its arbiter.
package set_job_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAITB,
        S_RUN,
        S_DONE
    } state_t;

    typedef logic req_idx_t;

    localparam int CEN_W        = 24;
    localparam int RAD_W        = 12;
    localparam int MODE_W       = 2;
    localparam int CAND_W       = 8;
    localparam int WDOG_W       = 8;
    localparam int WDOG_MAX_DEF = 80;

endpackage

// File: rtl/set_job_sched_rr_arb2.sv
// Two-input round-robin arbiter with a last-grant pointer.
// The pointer moves only when the update strobe marks a real grant.
module rr_arb2
    import set_job_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       upd,
    output logic [1:0] gnt
);

    req_idx_t last_q;

    // One-hot winner; on contention the side not granted last wins
    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

    // Pointer resets to "1 was last" so requester 0 is favoured first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (upd) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/set_job_sched.sv
// Scheduler in front of the SET circle-coverage engine: arbitrates two
// requesters, holds operands for the whole scan, and watchdogs the result.
module set_job_sched
    import set_job_sched_pkg::*;
#(
    parameter int WDOG_MAX = WDOG_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] central0,
    input  logic [23:0] central1,
    input  logic [11:0] radius0,
    input  logic [11:0] radius1,
    input  logic [1:0]  mode0,
    input  logic [1:0]  mode1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  cand_out,
    output logic        err_out,
    output logic        set_en,
    output logic [23:0] set_central,
    output logic [11:0] set_radius,
    output logic [1:0]  set_mode,
    input  logic        set_busy,
    input  logic        set_valid,
    input  logic [7:0]  set_candidate,
    output logic        sched_busy
);

    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_MAX - 1);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        arb_gnt;
    logic              grant;
    logic              waiting;
    logic              tmo;
    req_idx_t          owner_q;
    logic [WDOG_W-1:0] wdog_q;
    logic [CAND_W-1:0] cand_q;
    logic              err_q;

    assign grant   = (state_q == S_IDLE) && (req0 || req1);
    assign waiting = (state_q == S_WAITB) || (state_q == S_RUN);
    assign tmo     = waiting && (wdog_q == WDOG_LIM);

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .upd  (grant),
        .gnt  (arb_gnt)
    );

    // Next-state logic; a valid result always beats a same-cycle timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d = S_WAITB;
            end
            S_WAITB: begin
                if (set_valid)     state_d = S_DONE;
                else if (tmo)      state_d = S_DONE;
                else if (set_busy) state_d = S_RUN;
            end
            S_RUN: begin
                if (set_valid || tmo) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset drops any job in flight without a done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operands and owner load only on a grant so SET sees them stable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_central <= '0;
            set_radius  <= '0;
            set_mode    <= '0;
            owner_q     <= 1'b0;
        end else if (grant) begin
            owner_q <= arb_gnt[1];
            if (arb_gnt[1]) begin
                set_central <= central1;
                set_radius  <= radius1;
                set_mode    <= mode1;
            end else begin
                set_central <= central0;
                set_radius  <= radius0;
                set_mode    <= mode0;
            end
        end
    end

    // Watchdog clears on launch and counts while waiting for SET
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else if (state_q == S_LAUNCH) begin
            wdog_q <= '0;
        end else if (waiting) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    // Result capture: SET result if valid, otherwise an error on timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q <= '0;
            err_q  <= 1'b0;
        end else if (waiting && set_valid) begin
            cand_q <= set_candidate;
            err_q  <= 1'b0;
        end else if (tmo) begin
            cand_q <= '0;
            err_q  <= 1'b1;
        end
    end

    assign gnt0       = rst && grant && arb_gnt[0];
    assign gnt1       = rst && grant && arb_gnt[1];
    assign done0      = (state_q == S_DONE) && !owner_q;
    assign done1      = (state_q == S_DONE) && owner_q;
    assign set_en     = (state_q == S_LAUNCH);
    assign cand_out   = cand_q;
    assign err_out    = err_q;
    assign sched_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_set_job_sched.sv
// Directed bench for set_job_sched with a behavioural SET engine.
// Expected values are hand-computed constants.
module tb_set_job_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [23:0] central0 = '0, central1 = '0;
    logic [11:0] radius0 = '0, radius1 = '0;
    logic [1:0]  mode0 = '0, mode1 = '0;
    logic        gnt0, gnt1, done0, done1, err_out, set_en, sched_busy;
    logic [7:0]  cand_out;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy, set_valid;
    logic [7:0]  set_candidate;

    int n_vec = 0;
    int n_bad = 0;

    set_job_sched #(.WDOG_MAX(80)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .central0(central0), .central1(central1),
        .radius0(radius0), .radius1(radius1),
        .mode0(mode0), .mode1(mode1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .cand_out(cand_out), .err_out(err_out),
        .set_en(set_en),
        .set_central(set_central), .set_radius(set_radius),
        .set_mode(set_mode),
        .set_busy(set_busy), .set_valid(set_valid),
        .set_candidate(set_candidate),
        .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    // Behavioural SET: counts grid points inside circle 1 (8x8 grid)
    int   valid_delay = 64;
    bit   never = 1'b0;
    int   mcnt;
    bit   mrun;
    logic [7:0] mres;

    function automatic logic [7:0] circle(input logic [23:0] c,
                                          input logic [11:0] r);
        int cx, cy, rr, n;
        cx = int'(c[23:20]);
        cy = int'(c[19:16]);
        rr = int'(r[11:8]);
        n = 0;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                if ((x-cx)*(x-cx) + (y-cy)*(y-cy) <= rr*rr) n++;
        return 8'(n);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_busy <= 1'b0; set_valid <= 1'b0;
            set_candidate <= 8'h0; mcnt <= 0; mrun <= 1'b0; mres <= 8'h0;
        end else begin
            set_valid <= 1'b0;
            if (set_en) begin
                mrun <= 1'b1; mcnt <= 1; set_busy <= 1'b1;
                mres <= circle(set_central, set_radius);
            end else if (mrun) begin
                if (mcnt == valid_delay) begin
                    mrun <= 1'b0; set_busy <= 1'b0;
                    if (!never) begin
                        set_valid <= 1'b1; set_candidate <= mres;
                    end
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end
    end

    // Observation record filled by watch
    int en_k, en_n, d0_k, d1_k, d0_n, d1_n, g0_n, g1_n, cen_bad;
    logic [7:0]  d_cand;
    logic        d_err;
    logic [23:0] exp_cen;
    bit          jitter = 1'b0;

    task automatic start_req(input bit who, input logic [23:0] c,
                             input logic [11:0] r, input logic [1:0] m,
                             output logic g_ok);
        @(negedge clk);
        if (who) begin
            req1 = 1'b1; central1 = c; radius1 = r; mode1 = m;
        end else begin
            req0 = 1'b1; central0 = c; radius0 = r; mode0 = m;
        end
        #1 g_ok = who ? (gnt1 && !gnt0) : (gnt0 && !gnt1);
        @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic watch(input int ncyc);
        en_k = 0; en_n = 0; d0_k = 0; d1_k = 0; d0_n = 0; d1_n = 0;
        g0_n = 0; g1_n = 0; cen_bad = 0; d_cand = 8'hxx; d_err = 1'bx;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (jitter) central1 = 24'($urandom);
            #1;
            if (d0_k == 0 && d1_k == 0 && set_central !== exp_cen) cen_bad++;
            if (set_en) begin en_n++; if (en_k == 0) en_k = k; end
            if (gnt0) g0_n++;
            if (gnt1) g1_n++;
            if (done0) begin
                d0_n++; if (d0_k == 0) d0_k = k;
                d_cand = cand_out; d_err = err_out;
            end
            if (done1) begin
                d1_n++; if (d1_k == 0) d1_k = k;
                d_cand = cand_out; d_err = err_out;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] o;
        #1;
        o = {gnt0, gnt1, done0, done1, set_en, err_out, sched_busy, 1'b0};
        n_vec++;
        if (o !== 8'h00) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 00000000", o);
        end
        n_vec++;
        if (cand_out !== 8'd0) begin
            n_bad++; $display("FAIL reset_cand: got %0d want 0", cand_out);
        end
        n_vec++;
        if ({set_central, set_radius, set_mode} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_ops: got %h %h %h want 0",
                     set_central, set_radius, set_mode);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic ok;
        start_req(1'b0, 24'h444000, 12'h300, 2'd0, ok);
        exp_cen = 24'h444000;
        watch(75);
        n_vec++; if (ok !== 1'b1) begin n_bad++;
            $display("FAIL single_gnt0: got %b want 1", ok); end
        n_vec++; if (en_k != 1 || en_n != 1) begin n_bad++;
            $display("FAIL single_en: got k=%0d n=%0d want k=1 n=1", en_k, en_n); end
        n_vec++; if (d0_k != 67 || d0_n != 1) begin n_bad++;
            $display("FAIL single_done_lat: got k=%0d n=%0d want 67 1", d0_k, d0_n); end
        n_vec++; if (d_cand !== 8'd29) begin n_bad++;
            $display("FAIL single_cand: got %0d want 29", d_cand); end
        n_vec++; if (d_err !== 1'b0) begin n_bad++;
            $display("FAIL single_err: got %b want 0", d_err); end
        n_vec++; if (d1_n != 0) begin n_bad++;
            $display("FAIL single_done1: got %0d pulses want 0", d1_n); end
        n_vec++; if (cen_bad != 0 || set_radius !== 12'h300) begin n_bad++;
            $display("FAIL single_ops: got bad=%0d rad=%h want 0 300", cen_bad, set_radius); end
        n_vec++; if (sched_busy !== 1'b0 || g0_n != 0) begin n_bad++;
            $display("FAIL single_idle: got busy=%b g0=%0d want 0 0", sched_busy, g0_n); end
    endtask

    task automatic test_back_to_back();
        int ngr, nd, lastg;
        logic lasto, who;
        do_reset();
        @(negedge clk);
        req0 = 1'b1; central0 = 24'h444000; radius0 = 12'h300; mode0 = 2'd1;
        req1 = 1'b1; central1 = 24'h000000; radius1 = 12'h100; mode1 = 2'd2;
        ngr = 0; nd = 0; lastg = 0; lasto = 1'b0;
        for (int c = 0; c < 6*68 + 20 && nd < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (ngr == 6 && c == lastg + 1) begin req0 = 1'b0; req1 = 1'b0; end
            if (gnt0 || gnt1) begin
                who = gnt1;
                n_vec++; if (gnt0 && gnt1) begin n_bad++;
                    $display("FAIL b2b_onehot: got both want one"); end
                n_vec++; if (who !== 1'(ngr % 2)) begin n_bad++;
                    $display("FAIL b2b_order: job %0d got %b want %0d", ngr, who, ngr % 2); end
                if (ngr > 0) begin
                    n_vec++; if (c - lastg != 68) begin n_bad++;
                        $display("FAIL b2b_period: got %0d want 68", c - lastg); end
                end
                n_vec++; if (set_en !== 1'b0) begin n_bad++;
                    $display("FAIL b2b_en_on_gnt: got 1 want 0"); end
                lastg = c; lasto = who; ngr++;
            end
            if (done0 || done1) begin
                n_vec++; if (done1 !== lasto || done0 === done1) begin n_bad++;
                    $display("FAIL b2b_route: got d0=%b d1=%b owner %b", done0, done1, lasto); end
                n_vec++; if (c - lastg != 67) begin n_bad++;
                    $display("FAIL b2b_lat: got %0d want 67", c - lastg); end
                n_vec++; if (cand_out !== (lasto ? 8'd3 : 8'd29)) begin n_bad++;
                    $display("FAIL b2b_cand: got %0d want %0d", cand_out, lasto ? 3 : 29); end
                nd++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_vec++; if (ngr != 6 || nd != 6) begin n_bad++;
            $display("FAIL b2b_count: got %0d grants %0d dones want 6 6", ngr, nd); end
    endtask

    task automatic test_stability();
        logic ok;
        jitter = 1'b1;
        start_req(1'b0, 24'h00a5c3, 12'h100, 2'd3, ok);
        exp_cen = 24'h00a5c3;
        watch(75);
        jitter = 1'b0;
        n_vec++; if (cen_bad != 0) begin n_bad++;
            $display("FAIL stab_central: got %0d bad cycles want 0", cen_bad); end
        n_vec++; if (set_central !== 24'h00a5c3 || set_mode !== 2'd3) begin n_bad++;
            $display("FAIL stab_after: got %h %0d want 00a5c3 3", set_central, set_mode); end
        n_vec++; if (d0_k != 67 || d_cand !== 8'd3 || g1_n != 0) begin n_bad++;
            $display("FAIL stab_done: got k=%0d cand=%0d g1=%0d want 67 3 0", d0_k, d_cand, g1_n); end
    endtask

    task automatic test_watchdog();
        logic ok;
        int dk, g1k, e1k;
        logic [7:0] c0, c1;
        logic e0, e1;
        never = 1'b1;
        start_req(1'b0, 24'h444000, 12'h300, 2'd1, ok);
        dk = 0; g1k = 0; e1k = 0; c0 = 8'hxx; e0 = 1'bx; c1 = 8'hxx; e1 = 1'bx;
        for (int k = 1; k <= 200 && e1k == 0; k++) begin
            @(negedge clk);
            if (g1k != 0 && k == g1k + 1) req1 = 1'b0;
            if (k == 80) begin
                req1 = 1'b1; central1 = 24'h000000; radius1 = 12'h100; mode1 = 2'd0;
            end
            #1;
            if (done0 && dk == 0) begin dk = k; c0 = cand_out; e0 = err_out; end
            if (gnt1 && g1k == 0) begin g1k = k; never = 1'b0; end
            if (done1) begin e1k = k; c1 = cand_out; e1 = err_out; end
        end
        req1 = 1'b0; never = 1'b0;
        n_vec++; if (dk != 82) begin n_bad++;
            $display("FAIL wdog_lat: got %0d want 82", dk); end
        n_vec++; if (e0 !== 1'b1 || c0 !== 8'd0) begin n_bad++;
            $display("FAIL wdog_result: got err=%b cand=%0d want 1 0", e0, c0); end
        n_vec++; if (g1k != 83) begin n_bad++;
            $display("FAIL wdog_next_gnt: got %0d want 83", g1k); end
        n_vec++; if (e1k != 150 || c1 !== 8'd3 || e1 !== 1'b0) begin n_bad++;
            $display("FAIL wdog_job1: got k=%0d cand=%0d err=%b want 150 3 0", e1k, c1, e1); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic [7:0] o;
        start_req(1'b0, 24'h444000, 12'h300, 2'd2, ok);
        repeat (32) @(negedge clk);
        #1;
        n_vec++; if (sched_busy !== 1'b1 || cand_out !== 8'd3) begin n_bad++;
            $display("FAIL rmid_pre: got busy=%b cand=%0d want 1 3", sched_busy, cand_out); end
        rst = 1'b0;
        req1 = 1'b1; central1 = 24'h444000; radius1 = 12'h300; mode1 = 2'd1;
        #1;
        o = {gnt0, gnt1, done0, done1, set_en, err_out, sched_busy, 1'b0};
        n_vec++; if (o !== 8'h00) begin n_bad++;
            $display("FAIL rmid_ctrl: got %b want 00000000", o); end
        n_vec++; if (cand_out !== 8'd0) begin n_bad++;
            $display("FAIL rmid_cand: got %0d want 0", cand_out); end
        n_vec++; if ({set_central, set_radius, set_mode} !== 38'd0) begin n_bad++;
            $display("FAIL rmid_ops: got %h %h %h want 0", set_central, set_radius, set_mode); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin n_bad++;
            $display("FAIL rmid_first_gnt: got g0=%b g1=%b want 0 1", gnt0, gnt1); end
        @(posedge clk);
        #1 req1 = 1'b0;
        exp_cen = 24'h444000;
        watch(75);
        n_vec++; if (d0_n != 0) begin n_bad++;
            $display("FAIL rmid_no_done0: got %0d pulses want 0", d0_n); end
        n_vec++; if (d1_k != 67 || d_cand !== 8'd29 || set_mode !== 2'd1) begin n_bad++;
            $display("FAIL rmid_job1: got k=%0d cand=%0d mode=%0d want 67 29 1", d1_k, d_cand, set_mode); end
    endtask

    task automatic test_coincide();
        logic ok;
        valid_delay = 79;
        start_req(1'b0, 24'h000000, 12'h100, 2'd0, ok);
        exp_cen = 24'h000000;
        watch(90);
        n_vec++; if (d0_k != 82 || d_err !== 1'b0 || d_cand !== 8'd3) begin n_bad++;
            $display("FAIL tie_valid_wins: got k=%0d err=%b cand=%0d want 82 0 3", d0_k, d_err, d_cand); end
        valid_delay = 80;
        start_req(1'b0, 24'h444000, 12'h300, 2'd0, ok);
        exp_cen = 24'h444000;
        watch(90);
        n_vec++; if (d0_k != 82 || d_err !== 1'b1 || d_cand !== 8'd0) begin n_bad++;
            $display("FAIL late_valid: got k=%0d err=%b cand=%0d want 82 1 0", d0_k, d_err, d_cand); end
        valid_delay = 64;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stability();
        test_watchdog();
        test_reset_mid();
        test_coincide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
